issue_stage: RTL and testbench
==============================

Name: issue_stage

Overview:
- Operand-read/issue stage between instruction decode and execute.
- Drives the register file read ports and holds a 32-entry busy-bit scoreboard of in-flight destination registers.
- Stalls on RAW/WAW hazards and clears scoreboard bits when writeback hits the register file write port.
- Presents issued instructions with captured operands to EX through a registered valid/ready output.

Parameters:
- XLEN, 64, data width of operands and PC
- UOP_W, 32, width of opaque decoded micro-op bundle passed through to EX

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  decode has an instruction
- o_ready  out  1  stage accepts instruction this cycle
- i_pc  in  XLEN  instruction PC
- i_uop  in  UOP_W  decoded control bundle
- i_rs1_addr / i_rs2_addr  in  5  source register indices
- i_rs1_en / i_rs2_en  in  1  source is actually read
- i_rd_addr  in  5  destination index
- i_rd_wen  in  1  instruction writes rd
- o_rs1_addr / o_rs2_addr  out  5  regfile read address (= i_rsX_addr, combinational)
- o_rs1_cen / o_rs2_cen  out  1  regfile read enable (= i_valid & i_rsX_en)
- i_rs1_rdata / i_rs2_rdata  in  XLEN  regfile read data (includes same-cycle write bypass)
- i_wb_wen  in  1  writeback write enable (same signal as regfile write port)
- i_wb_addr  in  5  writeback destination
- i_flush  in  1  kill output register contents and block accept
- o_valid  out  1  issued instruction valid to EX
- i_ready  in  1  EX accepts
- o_pc / o_uop  out  XLEN / UOP_W  registered pass-through
- o_rs1_data / o_rs2_data  out  XLEN  registered operands
- o_rd_addr / o_rd_wen  out  5 / 1  registered destination info

Behaviour:
- Reset (async, rst_n low): busy[31:0] = 0; o_valid = 0; o_pc, o_uop, o_rsX_data, o_rd_addr = 0; o_rd_wen = 0. Reset mid-operation discards everything; scoreboard clears in the same event.
- clr_vec: one-hot of i_wb_addr when i_wb_wen and i_wb_addr != 0.
- busy_eff = busy & ~clr_vec. Clearing writeback data arrives via the regfile bypass.
- hazard = (i_rs1_en & rs1 != 0 & busy_eff[rs1]) | (i_rs2_en & rs2 != 0 & busy_eff[rs2]) | (i_rd_wen & rd != 0 & busy_eff[rd]).
- slot_free = ~o_valid | i_ready.
- o_ready = ~hazard & slot_free & ~i_flush. Accept = i_valid & o_ready.
- On accept, next cycle:
  - o_valid = 1.
  - Outputs capture inputs; o_rsX_data = i_rsX_rdata, or 0 if rsX_en = 0.
  - busy[rd] is set if i_rd_wen & rd != 0.
- No accept and i_ready & o_valid: o_valid drops to 0.
- Stall (o_valid & ~i_ready): all outputs hold stable.
- Latency: 1 cycle from accept to o_valid. Throughput 1/cycle with no hazards.
- Same-cycle set and clear on one register: set wins. A clear for reg N and an issue writing reg N is legal because busy_eff masks the clear.
- x0 is never marked busy and never causes a hazard.
- i_flush:
  - Next cycle o_valid = 0.
  - If o_valid & o_rd_wen & o_rd_addr != 0 and EX did not take it this cycle (~i_ready), busy[o_rd_addr] is cleared, unless the same cycle's clr_vec already clears it.
  - Instructions already past this stage stay busy until their writeback.
  - No accept occurs during flush.
- Writeback to a non-busy register is legal and leaves busy unchanged.
- One outstanding write per register: guaranteed by the WAW stall.

Decomposition:
- Shared package holds XLEN, REG_ADDR_W = 5, NUM_REGS = 32, and the zero-register constant.
- One sub-module, sb_busy: 32-bit busy vector with set/clear ports, set-wins priority, async reset, and busy_eff output.
- Hazard logic and the output register stay in issue_stage.

Test Plan:
- Reset then issue add x3, x1, x2 with regfile returning 0x11/0x22, i_ready = 1 -> o_valid next cycle, o_rs1_data = 0x11, o_rs2_data = 0x22, busy[3] = 1.
- Issue writing x5, then next instruction reading x5 with no writeback -> o_ready = 0 until i_wb_wen = 1, i_wb_addr = 5; that same cycle o_ready = 1 and operand equals the wb data via bypass.
- Writer of x7 in flight, new instruction also writes x7 -> stalled (WAW) until writeback of x7; on the accept cycle busy[7] stays 1 (set wins).
- Instruction using x0 as rs1/rd with busy vector full of 1s on other regs -> accepted immediately; busy[0] stays 0.
- o_valid = 1 with rd = x9, i_ready = 0, assert i_flush -> o_valid = 0 next cycle, busy[9] = 0, o_ready = 0 during flush cycle.
- i_ready held 0 for 4 cycles with o_valid = 1 -> all outputs stable, o_ready = 0; release i_ready -> back-to-back issue resumes at 1/cycle.

Source files
------------

// File: rtl/issue_stage_pkg.sv
// Shared constants and helpers for the issue stage and its busy-bit scoreboard.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package issue_stage_pkg;

   localparam int XLEN       = 64;
   localparam int UOP_W      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   // One-hot select of a register index; x0 maps to an all-zero vector so it
   // can never be set, cleared or reported busy.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (addr != REG_ZERO) begin
         v[addr] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/issue_stage_sb_busy.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue, cleared on writeback/flush.
// Latency: busy_eff is combinational from state and writeback clear; state updates next cycle.
// Backpressure: none; set wins over any clear of the same register in the same cycle.
//
// Ports: clk/rst_n (async active-low); set_en/set_addr mark a destination busy;
// clr_vec is the writeback clear (also masks busy_eff); kill_vec is the flush clear;
// busy_eff is the busy vector with this cycle's writeback already applied.
module sb_busy
   import issue_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic [NUM_REGS-1:0]   clr_vec,
   input  logic [NUM_REGS-1:0]   kill_vec,
   output logic [NUM_REGS-1:0]   busy_eff
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] set_vec;

   always_comb begin
      busy_eff = busy_q & ~clr_vec;
      set_vec  = set_en ? reg_onehot(set_addr) : '0;
      // OR-ing the set last makes a same-cycle set beat any clear.
      busy_d   = (busy_eff & ~kill_vec) | set_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/issue_stage.sv
// Operand-read/issue stage: reads the regfile, stalls on RAW/WAW via the busy scoreboard, registers the issue to EX.
// Latency: 1 cycle from accept (i_valid & o_ready) to o_valid; 1 issue/cycle without hazards.
// Backpressure: o_ready drops on hazard, on a stalled output slot (o_valid & ~i_ready) or on flush; outputs hold while stalled.
//
// Ports: decode side i_valid/o_ready with i_pc/i_uop/source and destination fields;
// regfile read ports o_rsX_addr/o_rsX_cen -> i_rsX_rdata (same-cycle bypass included);
// writeback snoop i_wb_wen/i_wb_addr; i_flush; EX side o_valid/i_ready with registered payload.
module issue_stage #(
   parameter int XLEN  = issue_stage_pkg::XLEN,
   parameter int UOP_W = issue_stage_pkg::UOP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [UOP_W-1:0] i_uop,
   input  logic [4:0]       i_rs1_addr,
   input  logic [4:0]       i_rs2_addr,
   input  logic             i_rs1_en,
   input  logic             i_rs2_en,
   input  logic [4:0]       i_rd_addr,
   input  logic             i_rd_wen,
   output logic [4:0]       o_rs1_addr,
   output logic [4:0]       o_rs2_addr,
   output logic             o_rs1_cen,
   output logic             o_rs2_cen,
   input  logic [XLEN-1:0]  i_rs1_rdata,
   input  logic [XLEN-1:0]  i_rs2_rdata,
   input  logic             i_wb_wen,
   input  logic [4:0]       i_wb_addr,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_pc,
   output logic [UOP_W-1:0] o_uop,
   output logic [XLEN-1:0]  o_rs1_data,
   output logic [XLEN-1:0]  o_rs2_data,
   output logic [4:0]       o_rd_addr,
   output logic             o_rd_wen
);

   import issue_stage_pkg::*;

   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] kill_vec;
   logic [NUM_REGS-1:0] busy_eff;
   logic                hazard;
   logic                slot_free;
   logic                accept;
   logic                set_en;

   logic             valid_q,  valid_d;
   logic [XLEN-1:0]  pc_q,     pc_d;
   logic [UOP_W-1:0] uop_q,    uop_d;
   logic [XLEN-1:0]  rs1_q,    rs1_d;
   logic [XLEN-1:0]  rs2_q,    rs2_d;
   logic [4:0]       rd_q,     rd_d;
   logic             rd_wen_q, rd_wen_d;

   // Regfile read port is a straight pass-through of decode.
   assign o_rs1_addr = i_rs1_addr;
   assign o_rs2_addr = i_rs2_addr;
   assign o_rs1_cen  = i_valid & i_rs1_en;
   assign o_rs2_cen  = i_valid & i_rs2_en;

   always_comb begin
      clr_vec = i_wb_wen ? reg_onehot(i_wb_addr) : '0;

      // Checking against busy_eff lets a reader issue in the writeback cycle;
      // its operand arrives through the regfile bypass.
      hazard = (i_rs1_en && (i_rs1_addr != REG_ZERO) && busy_eff[i_rs1_addr]) ||
               (i_rs2_en && (i_rs2_addr != REG_ZERO) && busy_eff[i_rs2_addr]) ||
               (i_rd_wen && (i_rd_addr  != REG_ZERO) && busy_eff[i_rd_addr]);

      slot_free = ~valid_q | i_ready;
      o_ready   = ~hazard & slot_free & ~i_flush;
      accept    = i_valid & o_ready;
      set_en    = accept & i_rd_wen;

      // A flushed instruction that EX never took will not write back, so its
      // busy bit must be released here. One EX did take is EX's responsibility.
      kill_vec = (i_flush & valid_q & rd_wen_q & ~i_ready) ? reg_onehot(rd_q) : '0;
   end

   sb_busy u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (set_en),
      .set_addr (i_rd_addr),
      .clr_vec  (clr_vec),
      .kill_vec (kill_vec),
      .busy_eff (busy_eff)
   );

   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      uop_d    = uop_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      rd_wen_d = rd_wen_q;
      if (i_flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         pc_d     = i_pc;
         uop_d    = i_uop;
         rs1_d    = i_rs1_en ? i_rs1_rdata : '0;
         rs2_d    = i_rs2_en ? i_rs2_rdata : '0;
         rd_d     = i_rd_addr;
         rd_wen_d = i_rd_wen;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         uop_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         rd_wen_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         uop_q    <= uop_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         rd_wen_q <= rd_wen_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_pc       = pc_q;
   assign o_uop      = uop_q;
   assign o_rs1_data = rs1_q;
   assign o_rs2_data = rs2_q;
   assign o_rd_addr  = rd_q;
   assign o_rd_wen   = rd_wen_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage with a queue scoreboard and an independent output monitor.
module tb_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [63:0] i_pc;
   logic [31:0] i_uop;
   logic [4:0]  i_rs1_addr, i_rs2_addr;
   logic        i_rs1_en, i_rs2_en;
   logic [4:0]  i_rd_addr;
   logic        i_rd_wen;
   logic [4:0]  o_rs1_addr, o_rs2_addr;
   logic        o_rs1_cen, o_rs2_cen;
   logic [63:0] i_rs1_rdata, i_rs2_rdata;
   logic        i_wb_wen;
   logic [4:0]  i_wb_addr;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [63:0] o_pc;
   logic [31:0] o_uop;
   logic [63:0] o_rs1_data, o_rs2_data;
   logic [4:0]  o_rd_addr;
   logic        o_rd_wen;

   issue_stage dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_pc(i_pc), .i_uop(i_uop),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .i_rs1_en(i_rs1_en), .i_rs2_en(i_rs2_en),
      .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
      .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
      .o_rs1_cen(o_rs1_cen), .o_rs2_cen(o_rs2_cen),
      .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
      .i_wb_wen(i_wb_wen), .i_wb_addr(i_wb_addr), .i_flush(i_flush),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_pc(o_pc), .o_uop(o_uop),
      .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
      .o_rd_addr(o_rd_addr), .o_rd_wen(o_rd_wen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] uop;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [4:0]  rd;
      logic        wen;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [63:0] pc, input logic [4:0] r1, input logic e1,
                            input logic [4:0] r2, input logic e2, input logic [4:0] rd,
                            input logic w, input logic [63:0] d1, input logic [63:0] d2);
      i_valid = 1'b1; i_pc = pc; i_uop = pc[31:0] ^ 32'h5A5A_0000;
      i_rs1_addr = r1; i_rs1_en = e1; i_rs2_addr = r2; i_rs2_en = e2;
      i_rd_addr = rd; i_rd_wen = w; i_rs1_rdata = d1; i_rs2_rdata = d2;
      cur.pc = pc; cur.uop = pc[31:0] ^ 32'h5A5A_0000;
      cur.d1 = e1 ? d1 : 64'h0; cur.d2 = e2 ? d2 : 64'h0;
      cur.rd = rd; cur.wen = w;
   endtask

   // Called at a negedge: the instruction on the inputs must be accepted now.
   task automatic push_cur(input string nm);
      check(nm, o_ready, 1'b1);
      if (o_ready) q.push_back(cur);
   endtask

   // Monitor: every EX handshake must match the oldest expected issue.
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_issue: got pc %h expected no issue", o_pc);
         end else begin
            mon_e = q.pop_front();
            check("out_pc",  o_pc,       mon_e.pc);
            check("out_uop", o_uop,      mon_e.uop);
            check("out_rs1", o_rs1_data, mon_e.d1);
            check("out_rs2", o_rs2_data, mon_e.d2);
            check("out_rd",  o_rd_addr,  mon_e.rd);
            check("out_wen", o_rd_wen,   mon_e.wen);
         end
      end
   end

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_pc = '0; i_uop = '0;
      i_rs1_addr = '0; i_rs2_addr = '0; i_rs1_en = 1'b0; i_rs2_en = 1'b0;
      i_rd_addr = '0; i_rd_wen = 1'b0; i_rs1_rdata = '0; i_rs2_rdata = '0;
      i_wb_wen = 1'b0; i_wb_addr = '0; i_flush = 1'b0; i_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid",  o_valid, 1'b0);
      check("rst_pc",     o_pc, 64'h0);
      check("rst_rs1",    o_rs1_data, 64'h0);
      check("rst_rd_wen", o_rd_wen, 1'b0);
      check("rst_busy",   dut.u_sb.busy_q, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // add x3, x1, x2
      set_instr(64'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 64'h11, 64'h22);
      @(negedge clk);
      check("t1_cen1",  o_rs1_cen, 1'b1);
      check("t1_addr2", o_rs2_addr, 5'd2);
      push_cur("t1_ready");
      step();
      i_valid = 1'b0;
      @(negedge clk);
      check("t1_valid", o_valid, 1'b1);
      check("t1_busy3", dut.u_sb.busy_q[3], 1'b1);
      step();

      // RAW on x5, released by writeback with bypassed data
      set_instr(64'h104, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 64'h0, 64'h0);
      @(negedge clk); push_cur("t2_writer");
      step();
      set_instr(64'h108, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 64'hDEAD, 64'h11);
      @(negedge clk); check("t2_raw_stall_a", o_ready, 1'b0);
      step();
      @(negedge clk); check("t2_raw_stall_b", o_ready, 1'b0);
      step();
      i_wb_wen = 1'b1; i_wb_addr = 5'd5; i_rs1_rdata = 64'h55; cur.d1 = 64'h55;
      @(negedge clk); push_cur("t2_wb_release");
      step();
      i_wb_wen = 1'b0; i_valid = 1'b0;
      @(negedge clk);
      check("t2_busy5", dut.u_sb.busy_q[5], 1'b0);
      check("t2_busy6", dut.u_sb.busy_q[6], 1'b1);
      step();

      // WAW on x7; set wins over same-cycle clear
      set_instr(64'h10C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'h0, 64'h0);
      @(negedge clk); push_cur("t3_writer");
      step();
      set_instr(64'h110, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'h0, 64'h0);
      @(negedge clk); check("t3_waw_stall", o_ready, 1'b0);
      step();
      i_wb_wen = 1'b1; i_wb_addr = 5'd7;
      @(negedge clk); push_cur("t3_wb_release");
      step();
      i_wb_wen = 1'b0; i_valid = 1'b0;
      @(negedge clk); check("t3_busy7_set_wins", dut.u_sb.busy_q[7], 1'b1);
      step();

      // Drain scoreboard, then mark every register x1..x31 busy
      foreach (cur.rd[k]) begin end
      i_wb_wen = 1'b1; i_wb_addr = 5'd3; step();
      i_wb_addr = 5'd6; step();
      i_wb_addr = 5'd7; step();
      i_wb_wen = 1'b0;
      @(negedge clk); check("t4_busy_empty", dut.u_sb.busy_q, 32'h0);
      step();
      for (int r = 1; r < 32; r++) begin
         set_instr(64'h200 + 64'(4 * r), 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 64'h0, 64'h0);
         @(negedge clk); push_cur("t4_fill");
         step();
      end
      i_valid = 1'b0;
      @(negedge clk); check("t4_busy_full", dut.u_sb.busy_q, 32'hFFFF_FFFE);
      step();
      // x0 as source and destination is hazard-free and never marked busy
      set_instr(64'h300, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 64'h0, 64'h0);
      @(negedge clk); push_cur("t4_x0_accept");
      step();
      i_valid = 1'b0;
      @(negedge clk); check("t4_busy0", dut.u_sb.busy_q, 32'hFFFF_FFFE);
      step();

      // Flush of a stalled x9 writer releases busy[9]
      i_wb_wen = 1'b1; i_wb_addr = 5'd9;
      step();
      i_wb_wen = 1'b0; i_ready = 1'b0;
      set_instr(64'h310, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 64'h0, 64'h0);
      @(negedge clk); push_cur("t5_writer");
      step();
      set_instr(64'h314, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0);
      i_flush = 1'b1;
      @(negedge clk);
      check("t5_flush_ready", o_ready, 1'b0);
      check("t5_pre_valid", o_valid, 1'b1);
      if (q.size() > 0) void'(q.pop_back());
      step();
      i_flush = 1'b0; i_valid = 1'b0;
      @(negedge clk);
      check("t5_post_valid", o_valid, 1'b0);
      check("t5_busy", dut.u_sb.busy_q, 32'hFFFF_FDFE);
      step();

      // Output stall for 4 cycles, then back-to-back issue
      set_instr(64'h400, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 64'hA1, 64'hA2);
      @(negedge clk); push_cur("t6_a");
      step();
      set_instr(64'h404, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'hB1, 64'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t6_stall_ready", o_ready, 1'b0);
         check("t6_stall_valid", o_valid, 1'b1);
         check("t6_stall_pc", o_pc, 64'h400);
         check("t6_stall_rs1", o_rs1_data, 64'hA1);
         check("t6_stall_rd", o_rd_addr, 5'd10);
         step();
      end
      i_ready = 1'b1;
      @(negedge clk); push_cur("t6_b");
      step();
      set_instr(64'h408, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'hC1, 64'h0);
      @(negedge clk); push_cur("t6_c");
      step();
      set_instr(64'h40C, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'hD1, 64'h0);
      @(negedge clk); push_cur("t6_d");
      step();
      i_valid = 1'b0;

      for (int w = 0; w < 10 && q.size() > 0; w++) step();
      check("drain_queue_empty", 64'(q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
